// File: rtl/tlb_refill_ctrl_if.sv
// Bundle of the bank-side refill signals and the memory read port seen by tlb_refill_ctrl.
// The master modport is the refill controller; the slave modport is the bank/memory environment.
interface tlb_refill_ctrl_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  miss_cache;
    logic [ADDR_WIDTH-1:0] addr_cache;
    logic                  set_cache;
    logic                  busy_rd;
    logic [ADDR_WIDTH-1:0] addr_rd;
    logic [DATA_WIDTH-1:0] data_rd;
    logic                  wen_rd;
    logic                  set_rd;
    logic                  finish_rd;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_resp_valid;
    logic                  mem_resp_ready;
    logic [DATA_WIDTH-1:0] mem_resp_data;

    modport master (
        input  miss_cache, addr_cache, set_cache,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output busy_rd, addr_rd, data_rd, wen_rd, set_rd, finish_rd,
        output mem_req_valid, mem_req_addr, mem_resp_ready
    );

    modport slave (
        output miss_cache, addr_cache, set_cache,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  busy_rd, addr_rd, data_rd, wen_rd, set_rd, finish_rd,
        input  mem_req_valid, mem_req_addr, mem_resp_ready
    );
endinterface

// File: rtl/tlb_refill_ctrl.sv
// Line refill engine: on a bank miss, issues one memory read for the line, streams BANK_NUM
// response beats straight into the bank, then pulses finish_rd. One refill outstanding at a time.
module tlb_refill_ctrl #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int BANK_NUM   = 4
) (
    input  logic                clk,
    input  logic                rst,
    tlb_refill_ctrl_if.master   rf_if
);
    localparam int OFFSET_LEN = $clog2(BANK_NUM);
    localparam logic [OFFSET_LEN-1:0] LAST_BEAT = OFFSET_LEN'(BANK_NUM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RECV = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] line_addr_q;
    logic                  set_q;
    logic [OFFSET_LEN-1:0] beat_cnt_q;
    logic                  in_recv_s;

    // Refill sequencing: latch the miss, hold the request until accepted, count beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            line_addr_q <= '0;
            set_q       <= 1'b0;
            beat_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rf_if.miss_cache) begin
                        line_addr_q <= rf_if.addr_cache;
                        set_q       <= rf_if.set_cache;
                        beat_cnt_q  <= '0;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (rf_if.mem_req_ready) begin
                        state_q <= RECV;
                    end
                end
                RECV: begin
                    if (rf_if.mem_resp_valid) begin
                        if (beat_cnt_q == LAST_BEAT) begin
                            beat_cnt_q <= '0;
                            state_q    <= FIN;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + OFFSET_LEN'(1);
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Beats are written through in the cycle they arrive, so the write strobe follows resp_valid.
    assign in_recv_s            = (state_q == RECV);
    assign rf_if.busy_rd        = (state_q != IDLE);
    assign rf_if.mem_req_valid  = (state_q == REQ);
    assign rf_if.mem_req_addr   = {line_addr_q[ADDR_WIDTH-1:OFFSET_LEN], {OFFSET_LEN{1'b0}}};
    assign rf_if.mem_resp_ready = in_recv_s;
    assign rf_if.wen_rd         = in_recv_s & rf_if.mem_resp_valid;
    assign rf_if.data_rd        = in_recv_s ? rf_if.mem_resp_data : {DATA_WIDTH{1'b0}};
    assign rf_if.addr_rd        = {line_addr_q[ADDR_WIDTH-1:OFFSET_LEN], beat_cnt_q};
    assign rf_if.set_rd         = set_q;
    assign rf_if.finish_rd      = (state_q == FIN);

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// Scoreboard bench for tlb_refill_ctrl: expected bank writes are queued as beats are driven
// and matched against wen_rd/addr_rd/data_rd/set_rd on the falling edge.
module tb_tlb_refill_ctrl;
    localparam int AW = 64;
    localparam int DW = 64;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          set;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    int   total_cnt = 0;
    int   bad_cnt   = 0;
    int   fin_seen  = 0;
    int   fin_exp   = 0;
    wr_t  sb_q[$];

    tlb_refill_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rf_if ();

    tlb_refill_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_NUM(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .rf_if (rf_if)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Bank-side monitor: every write strobe must match the oldest queued beat.
    always @(negedge clk) begin
        wr_t e;
        if (rf_if.wen_rd === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("wen_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("addr_rd", rf_if.addr_rd, e.addr);
                check_eq("data_rd", rf_if.data_rd, e.data);
                check_eq("set_rd", {63'd0, rf_if.set_rd}, {63'd0, e.set});
            end
        end
        if (rf_if.finish_rd === 1'b1) fin_seen++;
    end

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_busy"}, {63'd0, rf_if.busy_rd}, 64'd0);
        check_eq({tag, "_wen"}, {63'd0, rf_if.wen_rd}, 64'd0);
        check_eq({tag, "_fin"}, {63'd0, rf_if.finish_rd}, 64'd0);
        check_eq({tag, "_reqv"}, {63'd0, rf_if.mem_req_valid}, 64'd0);
        check_eq({tag, "_rspr"}, {63'd0, rf_if.mem_resp_ready}, 64'd0);
    endtask

    // Starts on the cycle the miss is presented; returns on the first IDLE cycle after FIN.
    task automatic run_refill(input logic [AW-1:0] base, input logic set_v, input int req_wait,
                              input logic [15:0] gaps, input bit poke, input logic [DW-1:0] dbase);
        wr_t e;
        rf_if.miss_cache = 1'b1;
        rf_if.addr_cache = base;
        rf_if.set_cache  = set_v;
        @(negedge clk);
        check_eq("c0_busy", {63'd0, rf_if.busy_rd}, 64'd0);
        check_eq("c0_reqv", {63'd0, rf_if.mem_req_valid}, 64'd0);
        next_cycle();
        rf_if.miss_cache = 1'b0;
        rf_if.addr_cache = '0;
        rf_if.set_cache  = 1'b0;
        for (int w = 0; w <= req_wait; w++) begin
            rf_if.mem_req_ready = (w == req_wait);
            @(negedge clk);
            check_eq("req_valid", {63'd0, rf_if.mem_req_valid}, 64'd1);
            check_eq("req_addr", rf_if.mem_req_addr, base);
            check_eq("req_busy", {63'd0, rf_if.busy_rd}, 64'd1);
            check_eq("req_wen", {63'd0, rf_if.wen_rd}, 64'd0);
            check_eq("req_set", {63'd0, rf_if.set_rd}, {63'd0, set_v});
            next_cycle();
        end
        rf_if.mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < int'(gaps[4*i +: 4]); g++) begin
                rf_if.mem_resp_valid = 1'b0;
                @(negedge clk);
                check_eq("gap_wen", {63'd0, rf_if.wen_rd}, 64'd0);
                check_eq("gap_rspr", {63'd0, rf_if.mem_resp_ready}, 64'd1);
                next_cycle();
                rf_if.miss_cache = 1'b0;
            end
            rf_if.mem_resp_valid = 1'b1;
            rf_if.mem_resp_data  = dbase + DW'(i);
            if (poke && i == 1) begin
                rf_if.miss_cache = 1'b1;
                rf_if.addr_cache = 64'h80;
                rf_if.set_cache  = ~set_v;
            end
            e.addr = base + AW'(i);
            e.data = dbase + DW'(i);
            e.set  = set_v;
            sb_q.push_back(e);
            @(negedge clk);
            check_eq("beat_rspr", {63'd0, rf_if.mem_resp_ready}, 64'd1);
            check_eq("beat_busy", {63'd0, rf_if.busy_rd}, 64'd1);
            check_eq("beat_fin", {63'd0, rf_if.finish_rd}, 64'd0);
            next_cycle();
            rf_if.miss_cache = 1'b0;
            rf_if.addr_cache = '0;
            rf_if.set_cache  = 1'b0;
        end
        rf_if.mem_resp_valid = 1'b0;
        rf_if.mem_resp_data  = '0;
        fin_exp++;
        @(negedge clk);
        check_eq("fin_pulse", {63'd0, rf_if.finish_rd}, 64'd1);
        check_eq("fin_wen", {63'd0, rf_if.wen_rd}, 64'd0);
        check_eq("fin_busy", {63'd0, rf_if.busy_rd}, 64'd1);
        check_eq("fin_set", {63'd0, rf_if.set_rd}, {63'd0, set_v});
        next_cycle();
    endtask

    initial begin
        wr_t e;
        rst = 1'b1;
        rf_if.miss_cache     = 1'b0;
        rf_if.addr_cache     = '0;
        rf_if.set_cache      = 1'b0;
        rf_if.mem_req_ready  = 1'b0;
        rf_if.mem_resp_valid = 1'b0;
        rf_if.mem_resp_data  = '0;
        @(negedge clk);
        check_idle_zero("rst");
        check_eq("rst_addr_rd", rf_if.addr_rd, 64'd0);
        check_eq("rst_req_addr", rf_if.mem_req_addr, 64'd0);
        check_eq("rst_set_rd", {63'd0, rf_if.set_rd}, 64'd0);
        check_eq("rst_data_rd", rf_if.data_rd, 64'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // T1 nominal, T2 request backpressure, T3 response gaps, T4 miss while busy
        run_refill(64'h40, 1'b1, 0, 16'h0000, 1'b0, 64'hA0);
        run_refill(64'h40, 1'b1, 5, 16'h0000, 1'b0, 64'hC0);
        run_refill(64'h40, 1'b0, 0, 16'h0210, 1'b0, 64'hD0);
        run_refill(64'h40, 1'b1, 0, 16'h0000, 1'b1, 64'hE0);

        // T5 reset in the middle of RECV after two beats
        rf_if.miss_cache = 1'b1;
        rf_if.addr_cache = 64'h40;
        rf_if.set_cache  = 1'b1;
        next_cycle();
        rf_if.miss_cache    = 1'b0;
        rf_if.mem_req_ready = 1'b1;
        next_cycle();
        rf_if.mem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rf_if.mem_resp_valid = 1'b1;
            rf_if.mem_resp_data  = 64'hB0 + 64'(i);
            e.addr = 64'h40 + 64'(i);
            e.data = 64'hB0 + 64'(i);
            e.set  = 1'b1;
            sb_q.push_back(e);
            next_cycle();
        end
        rf_if.mem_resp_data = 64'hB2;
        rst = 1'b1;
        #1;
        check_idle_zero("mid_rst");
        check_eq("mid_rst_addr", rf_if.addr_rd, 64'd0);
        check_eq("mid_rst_set", {63'd0, rf_if.set_rd}, 64'd0);
        check_eq("mid_rst_data", rf_if.data_rd, 64'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_idle_zero("late_beat");
        next_cycle();
        rf_if.mem_resp_valid = 1'b0;
        rf_if.mem_resp_data  = '0;
        run_refill(64'h80, 1'b0, 0, 16'h0000, 1'b0, 64'h50);

        // T6 back-to-back misses
        run_refill(64'h100, 1'b1, 0, 16'h0000, 1'b0, 64'h10);
        run_refill(64'h140, 1'b0, 1, 16'h1001, 1'b0, 64'h20);

        @(negedge clk);
        check_idle_zero("end");
        check_eq("fin_count", 64'(fin_seen), 64'(fin_exp));
        check_eq("sb_left", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, bad=%0d", bad_cnt);
        $fatal(1, "watchdog");
    end
endmodule
